multicycle_control_unit: RTL
============================

# multicycle_control_unit

Sequential control unit for the multicycle RV32I core. It replaces the single-cycle combinational decoder and sequences each instruction through fetch, decode, execute, memory and writeback states, driving the shared-ALU/shared-memory datapath. It decodes all RV32I base opcodes (R, I-ALU, load, store, all six branches, JAL, JALR, LUI, AUIPC) and stalls on a ready handshake for variable-latency memory.

## Interface
- OP_W, 7, opcode field width
- F3_W, 3, funct3 width
- F7_W, 7, funct7 width
- INSTR_W, 32, instruction width
- ALUCTRL_W, 4, ALU control width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- instr  in  INSTR_W  current instruction from the instruction register
- mem_ready  in  1  memory completes the current request this cycle
- alu_zero / alu_lt / alu_ltu  in  1 each  ALU flags: result zero, signed less-than, unsigned less-than
- mem_req  out  1  memory access request, held until mem_ready
- mem_we  out  1  request is a write
- adr_src  out  1  0 = PC, 1 = ALU-out register
- ir_write, pc_write, reg_write  out  1 each  register write enables
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4
- alu_ctrl  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
- imm_src  out  3  0 I, 1 S, 2 B, 3 J, 4 U
- result_src  out  2  00 ALU-out register, 01 data register, 10 ALU result
- retire  out  1  one-cycle pulse on the final cycle of every instruction
- trap  out  1  illegal instruction halt (see Configuration)

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, UPPER, ALUWB, BRANCH, JALR, JAL, TRAP.
- FETCH: mem_req=1, adr_src=0, a=PC, b=4, add. On mem_ready: ir_write=1 and pc_write=1 for that cycle only, then DECODE; otherwise remain.
- DECODE: a=old PC, b=imm, add, imm_src=B for branch, J for JAL (target into ALU-out). Next state by opcode: load/store→MEMADR, 0x33→EXEC_R, 0x13→EXEC_I, LUI/AUIPC→UPPER, 0x63→BRANCH, 0x6F→JAL, 0x67→JALR, else illegal.
- MEMADR: a=rs1, b=imm (I for load, S for store), add → MEMREAD or MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1; on mem_ready → MEMWB. MEMWB: result_src=01, reg_write=1, retire → FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1; on mem_ready retire → FETCH.
- EXEC_R/EXEC_I: alu_ctrl from funct3/funct7 (sub/sra when funct7[5]=1; EXEC_I applies funct7[5] only for srai) → ALUWB.
- UPPER: imm_src=U, a=zero (LUI) or old PC (AUIPC), add → ALUWB.
- ALUWB: result_src=00, reg_write=1, retire → FETCH.
- BRANCH: a=rs1, b=rs2, sub, result_src=00; pc_write = taken per funct3 (beq zero, bne !zero, blt lt, bge !lt, bltu ltu, bgeu !ltu); retire → FETCH. funct3 2/3 is illegal.
- JALR: a=rs1, b=imm I, add (target into ALU-out) → JAL.
- JAL: a=old PC, b=4, add, result_src=00, pc_write=1 → ALUWB (link written).
- Unlisted outputs are 0 in every state.

## Timing
- Outputs are decoded from state; pc_write, ir_write and retire also depend on mem_ready/flags in the same cycle.
- rst_n low: state=FETCH immediately, all enables, mem_req, retire and trap 0. First cycle after release: mem_req=1.
- Reset mid-access drops mem_req asynchronously and abandons the instruction.
- Latency with zero-wait memory: branch 3, R/I/U/store 4, JAL 4, load 5, JALR 5 cycles; each wait cycle adds exactly one.

## Configuration
- ILLEGAL_TRAP_EN defined: an illegal opcode/funct3 in DECODE → TRAP; trap=1, no enables, no retire, held until reset.
- Undefined: illegal instruction retires as a NOP from DECODE → FETCH with retire=1; trap tied 0; TRAP unreachable.

## Structure
- Shared package rv_ctrl_pkg: state enum, opcode constants, alu_ctrl, imm_src, alu_src and result_src encodings.
- Sub-module alu_decoder: combinational funct3/funct7/op → alu_ctrl, shared by EXEC_R and EXEC_I.

## Test plan
- addi x1,x0,5 (0x00500093), mem_ready held high → FETCH, DECODE, EXEC_I, ALUWB; reg_write only in cycle 4, alu_ctrl=0, retire once.
- Fetch with mem_ready low 3 cycles → mem_req high 4 cycles; ir_write/pc_write single pulse in the ready cycle.
- bne x1,x2 (0x00209463): alu_zero=0 → pc_write in BRANCH; alu_zero=1 → no pc_write; both retire at cycle 3.
- lw x3,0(x1) (0x0000A183) → 5 cycles, result_src=01 in MEMWB; sw x2,0(x1) (0x0020A023) → mem_we=1 only in MEMWRITE.
- jalr x1,0(x2) (0x000100E7) → JALR, JAL, ALUWB; pc_write once, reg_write once.
- 0x00000000 → trap=1 and stuck (macro on) or NOP retire (macro off); rst_n low mid-MEMREAD → mem_req 0 at once, FETCH after release.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// datapath mux selects and ALU operations, plus the branch condition helper.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
        S_EXEC_I, S_UPPER, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // The ALU computes rs1-rs2 during BRANCH; funct3 picks which flag decides.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic lt, input logic ltu);
        case (f3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational funct3/funct7 to ALU operation decode for register and
// immediate arithmetic; funct7[5] selects sub only for register ops.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_f7b5,
    input  logic       i_is_rtype,
    output logic [3:0] o_alu_ctrl
);

    always_comb begin
        o_alu_ctrl = ALU_ADD;
        case (i_funct3)
            3'b000:  o_alu_ctrl = (i_is_rtype && i_f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  o_alu_ctrl = ALU_SLL;
            3'b010:  o_alu_ctrl = ALU_SLT;
            3'b011:  o_alu_ctrl = ALU_SLTU;
            3'b100:  o_alu_ctrl = ALU_XOR;
            3'b101:  o_alu_ctrl = i_f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  o_alu_ctrl = ALU_OR;
            default: o_alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM. Define ILLEGAL_TRAP_EN to halt in TRAP on an
// illegal instruction; otherwise illegal instructions retire as NOPs.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int OP_W      = 7,
    parameter int F3_W      = 3,
    parameter int F7_W      = 7,
    parameter int INSTR_W   = 32,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 mem_ready,
    input  logic                 alu_zero,
    input  logic                 alu_lt,
    input  logic                 alu_ltu,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [2:0]           imm_src,
    output logic [1:0]           result_src,
    output logic                 retire,
    output logic                 trap
);

`ifdef ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_t          r_state;
    logic [OP_W-1:0] w_op;
    logic [F3_W-1:0] w_f3;
    logic            w_f7b5;
    logic            w_illegal;
    logic [3:0]      w_dec_alu;
    logic            w_unused;

    logic       w_mem_req, w_mem_we, w_adr_src, w_ir_write, w_pc_write, w_reg_write, w_retire;
    logic [1:0] w_src_a, w_src_b, w_res_src;
    logic [3:0] w_alu_ctrl;
    logic [2:0] w_imm_src;

    assign w_op     = instr[OP_W-1:0];
    assign w_f3     = instr[14:12];
    assign w_f7b5   = instr[25+F7_W-2];
    assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        w_illegal = 1'b0;
        case (w_op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: w_illegal = 1'b0;
            OP_BRANCH: w_illegal = (w_f3[2:1] == 2'b01);
            default:   w_illegal = 1'b1;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_funct3   (w_f3),
        .i_f7b5     (w_f7b5),
        .i_is_rtype (r_state == S_EXEC_R),
        .o_alu_ctrl (w_dec_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_illegal) begin
                        r_state <= TRAP_EN ? S_TRAP : S_FETCH;
                    end else begin
                        case (w_op)
                            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                            OP_RTYPE:          r_state <= S_EXEC_R;
                            OP_ITYPE:          r_state <= S_EXEC_I;
                            OP_LUI, OP_AUIPC:  r_state <= S_UPPER;
                            OP_BRANCH:         r_state <= S_BRANCH;
                            OP_JAL:            r_state <= S_JAL;
                            default:           r_state <= S_JALR;
                        endcase
                    end
                end
                S_MEMADR:   r_state <= (w_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXEC_R, S_EXEC_I, S_UPPER: r_state <= S_ALUWB;
                S_JALR:     r_state <= S_JAL;
                S_JAL:      r_state <= S_ALUWB;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        w_adr_src   = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_reg_write = 1'b0;
        w_retire    = 1'b0;
        w_src_a     = SRCA_PC;
        w_src_b     = SRCB_RS2;
        w_res_src   = RES_ALUOUT;
        w_alu_ctrl  = ALU_ADD;
        w_imm_src   = IMM_I;
        case (r_state)
            S_FETCH: begin
                w_mem_req  = 1'b1;
                w_src_b    = SRCB_FOUR;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE: begin
                // Branch/JAL target is computed here while the ALU is otherwise idle.
                w_src_a  = SRCA_OLDPC;
                w_src_b  = SRCB_IMM;
                w_retire = w_illegal && !TRAP_EN;
                if (w_op == OP_BRANCH)   w_imm_src = IMM_B;
                else if (w_op == OP_JAL) w_imm_src = IMM_J;
            end
            S_MEMADR: begin
                w_src_a   = SRCA_RS1;
                w_src_b   = SRCB_IMM;
                w_imm_src = (w_op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_res_src   = RES_DATA;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_adr_src = 1'b1;
                w_retire  = mem_ready;
            end
            S_EXEC_R: begin
                w_src_a    = SRCA_RS1;
                w_alu_ctrl = w_dec_alu;
            end
            S_EXEC_I: begin
                w_src_a    = SRCA_RS1;
                w_src_b    = SRCB_IMM;
                w_alu_ctrl = w_dec_alu;
            end
            S_UPPER: begin
                w_src_a   = (w_op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_U;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                w_src_a    = SRCA_RS1;
                w_alu_ctrl = ALU_SUB;
                w_pc_write = branch_taken(w_f3, alu_zero, alu_lt, alu_ltu);
                w_retire   = 1'b1;
            end
            S_JALR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
            end
            S_JAL: begin
                // PC takes the target from ALU-out while the ALU forms the link.
                w_src_a    = SRCA_OLDPC;
                w_src_b    = SRCB_FOUR;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates every output so an in-flight request drops without waiting for a clock.
    assign mem_req    = rst_n & w_mem_req;
    assign mem_we     = rst_n & w_mem_we;
    assign adr_src    = rst_n & w_adr_src;
    assign ir_write   = rst_n & w_ir_write;
    assign pc_write   = rst_n & w_pc_write;
    assign reg_write  = rst_n & w_reg_write;
    assign retire     = rst_n & w_retire;
    assign alu_src_a  = rst_n ? w_src_a : 2'b00;
    assign alu_src_b  = rst_n ? w_src_b : 2'b00;
    assign alu_ctrl   = rst_n ? ALUCTRL_W'(w_alu_ctrl) : '0;
    assign imm_src    = rst_n ? w_imm_src : 3'b000;
    assign result_src = rst_n ? w_res_src : 2'b00;
    assign trap       = rst_n & TRAP_EN & (r_state == S_TRAP);

endmodule
